spi_cmd_master: RTL and testbench

Command-driven SPI master on the system clock, placed directly upstream of the SPI-slave/RAM wrapper and driving its `MOSI`/`SS_n` while sampling its `MISO`. It accepts one RAM command at a time over a valid/ready handshake and serialises it as one framed SPI transaction. For read-data commands it captures the 8-bit byte returned on `MISO` and presents it on a one-cycle response strobe. It is the bus-side stimulus engine for the memory subsystem, used by both the system-level bench and integration tops.

---
 rtl/spi_cmd_master.sv | 179 +++++++++++++++++
 tb/tb_spi_cmd_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// rtl/spi_cmd_master.sv - command-driven SPI master framing one RAM command per transaction
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; ready only while idle
//   cmd_op[1:0]             00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   cmd_payload[7:0]        address or data byte, shifted after the op bits
//   rsp_valid, rsp_data     one-cycle strobe with the byte read back on a rd-data frame
//   err                     one-cycle sequence-error pulse (optional check only)
//   busy                    high whenever a frame or the inter-frame gap is in progress
//   MOSI, MISO, SS_n        SPI pins toward the SPI-slave/RAM wrapper
//
// Optional feature: define SPI_CMD_MASTER_SEQ_CHECK_EN to reject a rd-data
// command that is not preceded by a rd-address command.
module spi_cmd_master #(
    parameter int RD_LAT = 2,
    parameter int GAP    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_payload,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       err,
    output logic       busy,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS_n
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEL   = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_END   = 3'd5;

    localparam logic [3:0] WAIT_LAST = 4'(RD_LAT - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

    logic [2:0] state;
    logic [3:0] cnt;
    logic [9:0] frame;
    logic [7:0] rx_shift;
    logic       rd_frame;
    logic       accept;
    logic       reject;

    assign accept = (state == ST_IDLE) && cmd_ready && cmd_valid;

`ifdef SPI_CMD_MASTER_SEQ_CHECK_EN
    logic rd_addr_pending;

    assign reject = accept && (cmd_op == 2'b11) && !rd_addr_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_pending <= 1'b0;
            err             <= 1'b0;
        end else begin
            err <= reject;
            if (accept) begin
                if (cmd_op == 2'b10) begin
                    rd_addr_pending <= 1'b1;
                end else if (cmd_op == 2'b11) begin
                    rd_addr_pending <= 1'b0;
                end
            end
        end
    end
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    // Outputs are registered: each branch loads the pin values for the state
    // being entered, so the pins change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            frame     <= 10'd0;
            rx_shift  <= 8'd0;
            rd_frame  <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (reject) begin
                        // Rejected rd-data: spend one cycle busy with SS_n high, then idle.
                        state     <= ST_END;
                        cnt       <= GAP_LAST;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else if (accept) begin
                        state     <= ST_SEL;
                        frame     <= {cmd_op, cmd_payload};
                        rd_frame  <= (cmd_op == 2'b11);
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        SS_n      <= 1'b0;
                        MOSI      <= cmd_op[1];
                    end
                end
                ST_SEL: begin
                    state <= ST_SHIFT;
                    cnt   <= 4'd0;
                    MOSI  <= frame[9];
                    frame <= {frame[8:0], 1'b0};
                end
                ST_SHIFT: begin
                    if (cnt == 4'd9) begin
                        cnt  <= 4'd0;
                        MOSI <= 1'b0;
                        if (rd_frame) begin
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_END;
                            SS_n  <= 1'b1;
                        end
                    end else begin
                        cnt   <= cnt + 4'd1;
                        MOSI  <= frame[9];
                        frame <= {frame[8:0], 1'b0};
                    end
                end
                ST_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state <= ST_READ;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_READ: begin
                    rx_shift <= {rx_shift[6:0], MISO};
                    if (cnt == 4'd7) begin
                        state     <= ST_END;
                        cnt       <= 4'd0;
                        SS_n      <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= {rx_shift[6:0], MISO};
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_END: begin
                    if (cnt == GAP_LAST) begin
                        state     <= ST_IDLE;
                        cnt       <= 4'd0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= 4'd0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    SS_n      <= 1'b1;
                    MOSI      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_master.sv
// tb/tb_spi_cmd_master.sv - directed self-checking bench for spi_cmd_master
module tb_spi_cmd_master;

    localparam int RD_LAT = 2;
    localparam int GAP    = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_payload = 8'h00;
    logic       MISO = 1'b0;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       err;
    logic       busy;
    logic       MOSI;
    logic       SS_n;

    int n_cmp = 0;
    int n_bad = 0;
    int prev_tail = 0;

    spi_cmd_master #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_payload (cmd_payload),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .err         (err),
        .busy        (busy),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .SS_n        (SS_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  payload;
        logic [7:0]  slave;
        int          exp_low;
        logic [10:0] exp_mosi;
        int          exp_rsp_k;
        logic [7:0]  exp_data;
        int          exp_err;
        int          exp_ready_k;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Cycle k counts from 1 = first cycle after the accepting edge; all
    // sampling is on the falling edge.
    task automatic do_frame(input int idx, input vec_t v);
        int k, low_cnt, rise_k, ready_k, rsp_cnt, rsp_k, err_cnt, extra_ones, waited, rd_start;
        logic [10:0] got_mosi;
        logic [7:0]  got_data;
        low_cnt = 0; rise_k = 0; ready_k = 0; rsp_cnt = 0; rsp_k = 0;
        err_cnt = 0; extra_ones = 0; waited = 0; got_mosi = '0; got_data = '0;
        rd_start = 12 + RD_LAT;
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("v%0d ready_before", idx), 32'(cmd_ready), 32'd1);
        if (prev_tail > 0)
            check($sformatf("v%0d ss_high_gap", idx), 32'(prev_tail + waited), 32'(GAP + 1));
        cmd_valid = 1'b1;
        cmd_op = v.op;
        cmd_payload = v.payload;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (k = 1; k <= 60; k++) begin
            if (k >= rd_start && k < rd_start + 8) MISO = v.slave[7 - (k - rd_start)];
            else MISO = 1'b0;
            if (!SS_n) begin
                low_cnt++;
                if (low_cnt <= 11) got_mosi = {got_mosi[9:0], MOSI};
                else if (MOSI) extra_ones++;
            end else if (low_cnt > 0 && rise_k == 0) begin
                rise_k = k;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_k = k;
                got_data = rsp_data;
            end
            if (err) err_cnt++;
            if (cmd_ready) begin
                ready_k = k;
                break;
            end
            @(negedge clk);
        end
        MISO = 1'b0;
        check($sformatf("v%0d ss_low_cycles", idx), 32'(low_cnt), 32'(v.exp_low));
        if (v.exp_low > 0) begin
            check($sformatf("v%0d mosi_bits", idx), 32'(got_mosi), 32'(v.exp_mosi));
            check($sformatf("v%0d ss_rise_k", idx), 32'(rise_k), 32'(v.exp_low + 1));
            check($sformatf("v%0d mosi_idle_low", idx), 32'(extra_ones), 32'd0);
        end else begin
            check($sformatf("v%0d ss_never_low", idx), 32'(rise_k), 32'd0);
        end
        check($sformatf("v%0d rsp_pulses", idx), 32'(rsp_cnt), (v.exp_rsp_k > 0) ? 32'd1 : 32'd0);
        if (v.exp_rsp_k > 0) begin
            check($sformatf("v%0d rsp_k", idx), 32'(rsp_k), 32'(v.exp_rsp_k));
            check($sformatf("v%0d rsp_data", idx), 32'(got_data), 32'(v.exp_data));
        end
        check($sformatf("v%0d err_pulses", idx), 32'(err_cnt), 32'(v.exp_err));
        check($sformatf("v%0d ready_k", idx), 32'(ready_k), 32'(v.exp_ready_k));
        prev_tail = (rise_k > 0 && ready_k > 0) ? (ready_k - rise_k + 1) : 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int accepts, falls, busy_ready, waited;
        logic prev_ss;

`ifdef SPI_CMD_MASTER_SEQ_CHECK_EN
        vecs[0] = '{2'b11, 8'h00, 8'hC3, 0, 11'b0, 0, 8'h00, 1, 2};
`else
        vecs[0] = '{2'b11, 8'h00, 8'hC3, 21, 11'b11100000000, 22, 8'hC3, 0, 23};
`endif
        vecs[1] = '{2'b00, 8'h3C, 8'h00, 11, 11'b00000111100, 0, 8'h00, 0, 13};
        vecs[2] = '{2'b01, 8'hF0, 8'h00, 11, 11'b00111110000, 0, 8'h00, 0, 13};
        vecs[3] = '{2'b10, 8'h3C, 8'h00, 11, 11'b11000111100, 0, 8'h00, 0, 13};
        vecs[4] = '{2'b11, 8'h00, 8'hA5, 21, 11'b11100000000, 22, 8'hA5, 0, 23};
        vecs[5] = '{2'b10, 8'h81, 8'h00, 11, 11'b11010000001, 0, 8'h00, 0, 13};
        vecs[6] = '{2'b11, 8'h5A, 8'h3C, 21, 11'b11101011010, 22, 8'h3C, 0, 23};
        vecs[7] = '{2'b01, 8'h00, 8'h00, 11, 11'b00100000000, 0, 8'h00, 0, 13};

        // Reset state
        @(negedge clk);
        check("rst ss_n", 32'(SS_n), 32'd1);
        check("rst mosi", 32'(MOSI), 32'd0);
        check("rst cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_data", 32'(rsp_data), 32'h00);
        check("rst err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst busy", 32'(busy), 32'd0);

        // Vector table, applied back to back
        for (int i = 0; i < 8; i++) do_frame(i, vecs[i]);

        // cmd_valid held through frames: one frame per accept, accepts only when idle
        accepts = 0; falls = 0; busy_ready = 0;
        prev_ss = SS_n;
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        cmd_payload = 8'h55;
        for (int n = 0; n < 60; n++) begin
            if (n == 30) cmd_valid = 1'b0;
            if (cmd_valid && cmd_ready) accepts++;
            if (prev_ss && !SS_n) falls++;
            if (busy && cmd_ready) busy_ready++;
            prev_ss = SS_n;
            @(negedge clk);
        end
        check("hold accepts", 32'(accepts), 32'd3);
        check("hold frames", 32'(falls), 32'd3);
        check("hold ready_while_busy", 32'(busy_ready), 32'd0);
        check("hold end_ready", 32'(cmd_ready), 32'd1);

        // Asynchronous reset in the middle of SHIFT
        check("pre_rst rsp_data", 32'(rsp_data), 32'h3C);
        waited = 0;
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        cmd_valid = 1'b1;
        cmd_op = 2'b00;
        cmd_payload = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midshift mosi", 32'(MOSI), 32'd1);
        check("midshift ss_n", 32'(SS_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst ss_n", 32'(SS_n), 32'd1);
        check("async_rst mosi", 32'(MOSI), 32'd0);
        check("async_rst cmd_ready", 32'(cmd_ready), 32'd0);
        check("async_rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("after_rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("after_rst rsp_data", 32'(rsp_data), 32'h00);
        check("after_rst ss_n", 32'(SS_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
